// File: rtl/sb_config_pkg.sv
// ============================================================================
// sb_config_pkg : shared defaults, FSM state type and counter sizing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package sb_config_pkg;

  localparam int c_NUM_MEM      = 18;
  localparam int c_BITS_PER_MEM = 2;
  localparam int c_ADDR_W       = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // A range of one still needs a one-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_frame_config_ctrl_if.sv
// ============================================================================
// sb_frame_config_ctrl_if : bitstream handshake and frame decoder write bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface sb_frame_config_ctrl_if #(
  parameter int ADDR_W = sb_config_pkg::c_ADDR_W
);

  logic              start;
  logic              abort;
  logic              cfg_valid;
  logic              cfg_bit;
  logic              cfg_ready;
  logic              enable;
  logic [0:ADDR_W-1] address;
  logic              data_in;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, cfg_valid, cfg_bit,
    input  cfg_ready, enable, address, data_in, busy, done
  );

  modport slave (
    input  start, abort, cfg_valid, cfg_bit,
    output cfg_ready, enable, address, data_in, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/sb_frame_config_ctrl.sv
// ============================================================================
// sb_frame_config_ctrl : serial bitstream to switch-block frame write sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module sb_frame_config_ctrl
  import sb_config_pkg::*;
#(
  parameter int NUM_MEM      = c_NUM_MEM,
  parameter int BITS_PER_MEM = c_BITS_PER_MEM,
  parameter int ADDR_W       = c_ADDR_W
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  sb_frame_config_ctrl_if.slave bus
);

  localparam int c_MEM_W = cnt_w(NUM_MEM);
  localparam int c_BIT_W = cnt_w(BITS_PER_MEM);
  localparam logic [c_MEM_W-1:0] c_MEM_LAST = c_MEM_W'(NUM_MEM - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(BITS_PER_MEM - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_MEM_W-1:0] r_mem_idx;
  logic [c_BIT_W-1:0] r_bit_idx;
  logic [0:ADDR_W-1] r_address;
  logic              r_data_in;

  logic              w_cfg_ready;
  logic              w_enable;
  logic              w_busy;
  logic              w_done;
  logic              w_handshake;
  logic              w_start_acc;
  logic              w_last;
  logic [ADDR_W-2:0] w_mem_field;
  logic [ADDR_W-1:0] w_addr_val;

  assign w_last      = (r_mem_idx == c_MEM_LAST) && (r_bit_idx == c_BIT_LAST);
  assign w_handshake = (r_state == ST_ACCEPT) && bus.cfg_valid && !bus.abort;
  assign w_start_acc = (r_state == ST_IDLE) && bus.start && !bus.abort;

  // Bit select lands in address[0], the most significant position of the value.
  assign w_mem_field = (ADDR_W - 1)'(r_mem_idx);
  assign w_addr_val  = {r_bit_idx[0], w_mem_field};

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.start) w_state_nxt = ST_ACCEPT;
        ST_ACCEPT: if (bus.cfg_valid) w_state_nxt = ST_STROBE;
        ST_STROBE: w_state_nxt = ST_HOLD;
        ST_HOLD:   w_state_nxt = w_last ? ST_FINISH : ST_ACCEPT;
        ST_FINISH: w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Strobes are masked by abort so a cancelled load never writes or completes.
  always_comb begin
    w_cfg_ready = 1'b0;
    w_enable    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        w_cfg_ready = !bus.abort;
        w_busy      = 1'b1;
      end
      ST_STROBE: begin
        w_enable = !bus.abort;
        w_busy   = 1'b1;
      end
      ST_HOLD:   w_busy = 1'b1;
      ST_FINISH: w_done = !bus.abort;
      default:   ;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_mem_idx <= '0;
      r_bit_idx <= '0;
    end else if (w_start_acc) begin
      r_mem_idx <= '0;
      r_bit_idx <= '0;
    end else if ((r_state == ST_HOLD) && !bus.abort && !w_last) begin
      if (r_bit_idx == c_BIT_LAST) begin
        r_bit_idx <= '0;
        r_mem_idx <= r_mem_idx + 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_address <= '0;
      r_data_in <= 1'b0;
    end else if (w_handshake) begin
      r_address <= w_addr_val;
      r_data_in <= bus.cfg_bit;
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.enable    = w_enable;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.address   = r_address;
  assign bus.data_in   = r_data_in;

endmodule

`default_nettype wire

// File: tb/tb_sb_frame_config_ctrl.sv
// ============================================================================
// tb_sb_frame_config_ctrl : directed bench with a transaction-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sb_frame_config_ctrl;

  localparam int NM    = 18;
  localparam int BPM   = 2;
  localparam int AW    = 6;
  localparam int NBITS = NM * BPM;

  typedef struct {
    logic [AW-1:0] a;
    logic          d;
  } wr_t;

  logic prog_clk = 1'b0;
  logic pReset;
  always #5 prog_clk = ~prog_clk;

  sb_frame_config_ctrl_if #(.ADDR_W(AW)) bus ();

  sb_frame_config_ctrl #(
    .NUM_MEM      (NM),
    .BITS_PER_MEM (BPM),
    .ADDR_W       (AW)
  ) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (bus)
  );

  logic [AW-1:0] addr_v;
  assign addr_v = bus.address;

  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0;
  int pat_sel = 0;
  wr_t wr_q[$];

  // Model: a load is NBITS slots; slot k writes mem k/BPM, bit k%BPM.
  bit            m_busy, m_fin;
  int            m_k, m_ph;
  logic [AW-1:0] m_addr;
  logic          m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic pat(input int sel, input int k);
    return (sel == 0) ? (k % 2 == 0) : (k % 3 == 1);
  endfunction

  function automatic logic [AW-1:0] slot_addr(input int k);
    return AW'((k % BPM) * (1 << (AW - 1)) + k / BPM);
  endfunction

  always @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      m_busy = 0; m_fin = 0; m_k = 0; m_ph = 0; m_addr = '0; m_data = 1'b0;
    end else if (bus.abort) begin
      m_busy = 0; m_fin = 0; m_ph = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_busy) begin
      if (bus.start) begin m_busy = 1; m_k = 0; m_ph = 0; end
    end else if (m_ph == 0) begin
      if (bus.cfg_valid) begin
        m_ph = 1; m_addr = slot_addr(m_k); m_data = bus.cfg_bit;
      end
    end else if (m_ph == 1) begin
      m_ph = 2;
    end else if (m_k == NBITS - 1) begin
      m_busy = 0; m_fin = 1; m_ph = 0;
    end else begin
      m_k++; m_ph = 0;
    end
  end

  always @(negedge prog_clk) begin
    logic [9:0] act, exp;
    act = {bus.cfg_ready, bus.enable, bus.busy, bus.done, addr_v, bus.data_in};
    exp = {m_busy && m_ph == 0 && !bus.abort, m_busy && m_ph == 1 && !bus.abort,
           m_busy, m_fin && !bus.abort, m_addr, m_data};
    chk("cycle{rdy,en,busy,done,addr,data}", 32'(act), 32'(exp));
    if (bus.enable) wr_q.push_back('{a: addr_v, d: bus.data_in});
    if (bus.done) n_done++;
  end

  task automatic tick();
    @(posedge prog_clk);
    #2;
  endtask

  task automatic begin_load();
    wr_q.delete();
    n_done = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in the first ACCEPT cycle; returns cycles until FINISH or -1.
  task automatic drive_bits(input int gap_mode, input int start_mode, input int budget,
                            output int cyc_to_done);
    cyc_to_done = -1;
    for (int c = 0; c < budget; c++) begin
      if (bus.done && cyc_to_done < 0) cyc_to_done = c;
      bus.cfg_valid = (gap_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.cfg_bit   = pat(pat_sel, m_k);
      bus.start     = (start_mode != 0) && ((c % 7 == 3) || bus.done);
      tick();
      if (cyc_to_done >= 0 && c >= cyc_to_done + 3) break;
    end
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic check_writes(input int sel);
    chk("write_count", wr_q.size(), NBITS);
    for (int k = 0; k < wr_q.size() && k < NBITS; k++) begin
      chk($sformatf("wr%0d_addr", k), 32'(wr_q[k].a), 32'(slot_addr(k)));
      chk($sformatf("wr%0d_data", k), 32'(wr_q[k].d), 32'(pat(sel, k)));
    end
  endtask

  task automatic run_to(input logic [AW-1:0] target, output bit found);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = pat(pat_sel, m_k);
      if (bus.enable && addr_v == target) found = 1;
      else tick();
    end
  endtask

  initial begin
    int  cd;
    bit  found;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;
    pReset = 1'b1;
    repeat (3) tick();
    chk("reset_state", 32'({bus.cfg_ready, bus.enable, bus.busy, bus.done, addr_v, bus.data_in}), 0);
    pReset = 1'b0;
    tick();

    // Full load, valid held high, 1010... pattern
    pat_sel = 0;
    begin_load();
    drive_bits(0, 0, 300, cd);
    chk("full_done_cycle", cd, 108);
    chk("full_done_pulses", n_done, 1);
    check_writes(0);
    if (wr_q.size() == NBITS) begin
      chk("lit_addr0", 32'(wr_q[0].a), 32'h00);
      chk("lit_addr1", 32'(wr_q[1].a), 32'h20);
      chk("lit_addr2", 32'(wr_q[2].a), 32'h01);
      chk("lit_addr3", 32'(wr_q[3].a), 32'h21);
      chk("lit_addr34", 32'(wr_q[34].a), 32'h11);
      chk("lit_addr35", 32'(wr_q[35].a), 32'h31);
      chk("lit_data0", 32'(wr_q[0].d), 1);
      chk("lit_data1", 32'(wr_q[1].d), 0);
    end

    // Random valid gaps
    pat_sel = 1;
    begin_load();
    drive_bits(1, 0, 800, cd);
    chk("gap_done_seen", 32'(cd >= 0), 1);
    chk("gap_done_pulses", n_done, 1);
    check_writes(1);

    // Abort and start together in IDLE: abort wins
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_start_busy", bus.busy, 0);
    tick();
    chk("abort_start_stays_idle", bus.busy, 0);

    // Abort during STROBE of mem 5
    pat_sel = 0;
    begin_load();
    run_to(AW'(5), found);
    chk("reach_mem5_strobe", found, 1);
    bus.abort = 1'b1; bus.cfg_valid = 1'b0;
    #1;
    chk("abort_enable_masked", bus.enable, 0);
    tick();
    bus.abort = 1'b0;
    chk("abort_enable_next", bus.enable, 0);
    chk("abort_busy_next", bus.busy, 0);
    repeat (5) tick();
    chk("abort_no_done", n_done, 0);
    begin_load();
    drive_bits(0, 0, 300, cd);
    chk("restart_done_cycle", cd, 108);
    check_writes(0);

    // Asynchronous reset in the middle of HOLD
    begin_load();
    run_to(AW'(6'h21), found);
    chk("reach_0x21_strobe", found, 1);
    tick();
    #1;
    pReset = 1'b1;
    #1;
    chk("async_reset_outputs",
        32'({bus.cfg_ready, bus.enable, bus.busy, bus.done, addr_v, bus.data_in}), 0);
    bus.cfg_valid = 1'b0;
    tick(); tick();
    pReset = 1'b0;
    tick();

    // Start pulses while busy and in FINISH are ignored
    pat_sel = 0;
    begin_load();
    drive_bits(0, 1, 300, cd);
    chk("startpulse_done_cycle", cd, 108);
    repeat (4) tick();
    chk("startpulse_done_pulses", n_done, 1);
    chk("startpulse_idle_after", bus.busy, 0);
    check_writes(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
